// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline register (main + skid) with flush/stall; PIPE_STAGE_PERF_EN adds stall/flush counters.
// Latency 1 cycle accept-to-valid; in_ready depends only on held state, stall and flush.
module pipe_stage_elastic #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_valid, skid_valid;
  logic             in_fire, out_fire;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);

  assign in_ready  = ~skid_valid & ~stall & ~flush;
  assign out_valid = main_valid & ~stall & ~flush;
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else if (!stall) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        TWO: begin
          // Skid promotes to main; the freed slot reads as zero.
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] cnt_one;

  assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating counters; flush leaves them alone, only reset clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + cnt_one;
      end
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + cnt_one;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed plus randomized checks of pipe_stage_elastic against a queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int WIDTH = 64;
  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             stall;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             in_ready3, out_valid3;
  logic [WIDTH-1:0] out_data3;
  logic [1:0]       occupancy3;
  logic [2:0]       stall_cycles3;
  logic [2:0]       flush_count3;
`endif

  pipe_stage_elastic #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_elastic #(.WIDTH(WIDTH), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready),
    .occupancy(occupancy3),
    .stall_cycles(stall_cycles3), .flush_count(flush_count3)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] q[$];
  longint sc, fc, sc3, fc3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat_inc(input longint v, input longint maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // One cycle: drive inputs after the falling edge, check outputs, then advance the model.
  task automatic step(input logic rst, input logic fl, input logic st, input logic iv,
                      input logic [WIDTH-1:0] id, input logic ordy);
    logic exp_rdy, exp_vld;
    logic [WIDTH-1:0] exp_dat;
    @(negedge clk);
    reset = rst; flush = fl; stall = st; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) && !st && !fl;
    exp_vld = (q.size() > 0) && !st && !fl;
    exp_dat = (q.size() > 0) ? q[0] : '0;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_vld));
    chk("out_data", out_data, exp_dat);
    chk("occupancy", 64'(occupancy), 64'(q.size()));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(sc));
    chk("flush_count", 64'(flush_count), 64'(fc));
    chk("stall_cycles_w3", 64'(stall_cycles3), 64'(sc3));
    chk("flush_count_w3", 64'(flush_count3), 64'(fc3));
`endif
    if (rst) begin
      q.delete();
      sc = 0; fc = 0; sc3 = 0; fc3 = 0;
    end else begin
      if (fl) q.delete();
      else if (!st) begin
        if (exp_vld && ordy) void'(q.pop_front());
        if (iv && exp_rdy) q.push_back(id);
      end
      if (st) begin sc = sat_inc(sc, 64'hFFFF_FFFF); sc3 = sat_inc(sc3, 7); end
      if (fl) begin fc = sat_inc(fc, 64'hFFFF_FFFF); fc3 = sat_inc(fc3, 7); end
    end
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, ordy);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    sc = 0; fc = 0; sc3 = 0; fc3 = 0;
    repeat (2) @(posedge clk);

    // Reset state, then back-to-back stream.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h22, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h33, 1'b1);
    idle(1'b1, 2);

    // Skid fill, hold under back-pressure, drain.
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hA0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hA1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hAF, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // Stall freeze with both entries held.
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hB0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hB1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 64'hDEAD, 1'b1);
    idle(1'b1, 3);

    // Flush beats stall and rejects a concurrent beat.
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hD0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hD1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'hC0, 1'b1);
    idle(1'b1, 2);

    // Mid-operation reset.
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hE0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 64'hE1, 1'b0);
    idle(1'b1, 1);

    // Counter accumulation and saturation of the narrow instance.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    idle(1'b1, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
